// File: rtl/vga_fb_reader_if.sv
// Framebuffer read port between vga_fb_reader (master) and a synchronous-read RAM (slave).
interface vga_fb_reader_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int PIX_WIDTH  = 12
) ();

  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [PIX_WIDTH-1:0]  mem_rdata;

  modport master (
    output mem_re,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_re,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: fetches one pixel per active cycle from a synchronous-read framebuffer
// (or generates a test pattern) and re-aligns hs/vs/pixel_enable with the fetch latency.
// Line start addresses are accumulated from a stride so no multiplier is needed.
module vga_fb_reader #(
  parameter int H_WIDTH    = 11,
  parameter int V_WIDTH    = 10,
  parameter int ADDR_WIDTH = 19,
  parameter int PIX_WIDTH  = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  vga_hs_i,
  input  logic                  vga_vs_i,
  input  logic                  pixel_enable_i,
  input  logic [H_WIDTH-1:0]    hcount_i,
  input  logic [V_WIDTH-1:0]    vcount_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic                  pattern_en_i,
  input  logic                  we_i,
  vga_fb_reader_if.master       mem_if,
  output logic                  vga_hs_o,
  output logic                  vga_vs_o,
  output logic                  pixel_valid_o,
  output logic [PIX_WIDTH-1:0]  rgb_o
);

  // Total pipeline depth: address register, RD_LATENCY RAM cycles, output register.
  localparam int LAT = RD_LATENCY + 2;

  // Configuration registers: shadow is written any time, active only follows during vsync.
  logic [ADDR_WIDTH-1:0] shadow_base_q;
  logic [ADDR_WIDTH-1:0] shadow_stride_q;
  logic                  shadow_pat_q;
  logic [ADDR_WIDTH-1:0] active_stride_q;
  logic                  active_pat_q;

  // Address generation (stage 1).
  logic                  pe_prev_q;
  logic [ADDR_WIDTH-1:0] line_base_q;
  logic [ADDR_WIDTH-1:0] line_base_d;
  logic                  mem_re_q;
  logic                  mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  // Timing delay lines; bit 0 is stage 1, bit LAT-1 drives the output pins.
  logic [LAT-1:0]        hs_sr_q;
  logic [LAT-1:0]        vs_sr_q;
  logic [LAT-1:0]        pe_sr_q;

  // Pattern select and pattern pixel only need to reach the stage feeding the
  // output register; the output register itself is their final stage.
  logic [LAT-2:0]        sel_sr_q;
  logic [PIX_WIDTH-1:0]  pat_sr_q [LAT-1];
  logic [PIX_WIDTH-1:0]  pat_d;

  logic [PIX_WIDTH-1:0]  rgb_q;
  logic [PIX_WIDTH-1:0]  rgb_d;

  // Upper vcount bits do not contribute to the 4-bit test pattern.
  logic                  unused_vcount;
  assign unused_vcount = ^vcount_i[V_WIDTH-1:4];

  // Shadow config capture on write strobe.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shadow_base_q   <= '0;
      shadow_stride_q <= '0;
      shadow_pat_q    <= 1'b0;
    end else if (we_i) begin
      shadow_base_q   <= base_addr_i;
      shadow_stride_q <= stride_i;
      shadow_pat_q    <= pattern_en_i;
    end
  end

  // Active config follows shadow only while vsync is asserted, so a frame never
  // sees a config change. The active base lives in line_base_q, which reloads
  // from the shadow base during vsync.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      active_stride_q <= '0;
      active_pat_q    <= 1'b0;
    end else if (!vga_vs_i) begin
      active_stride_q <= shadow_stride_q;
      active_pat_q    <= shadow_pat_q;
    end
  end

  // Line base: reload in vsync, step by stride at the end of each active line.
  always_comb begin
    line_base_d = line_base_q;
    if (!vga_vs_i) begin
      line_base_d = shadow_base_q;
    end else if (pe_prev_q && !pixel_enable_i) begin
      line_base_d = line_base_q + active_stride_q;
    end
  end

  // Read request and address; address holds whenever no read is issued.
  always_comb begin
    mem_re_d   = pixel_enable_i & ~active_pat_q;
    mem_addr_d = mem_addr_q;
    if (mem_re_d) begin
      mem_addr_d = line_base_q + ADDR_WIDTH'(hcount_i);
    end
  end

  // Stage-1 address registers and pixel-enable edge history.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pe_prev_q   <= 1'b0;
      line_base_q <= '0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      pe_prev_q   <= pixel_enable_i;
      line_base_q <= line_base_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Test pattern: {h[3:0], v[3:0], h^v}, MSBs zero when the pixel is wider than 12 bits.
  always_comb begin
    pat_d        = '0;
    pat_d[11:8]  = hcount_i[3:0];
    pat_d[7:4]   = vcount_i[3:0];
    pat_d[3:0]   = hcount_i[3:0] ^ vcount_i[3:0];
  end

  // Sync and enable delay lines; sync lines reset to their inactive (high) level.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hs_sr_q <= '1;
      vs_sr_q <= '1;
      pe_sr_q <= '0;
    end else begin
      hs_sr_q <= {hs_sr_q[LAT-2:0], vga_hs_i};
      vs_sr_q <= {vs_sr_q[LAT-2:0], vga_vs_i};
      pe_sr_q <= {pe_sr_q[LAT-2:0], pixel_enable_i};
    end
  end

  // Pattern select and pattern pixel delay lines, aligned with RAM read data.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sel_sr_q <= '0;
      for (int i = 0; i < LAT - 1; i++) begin
        pat_sr_q[i] <= '0;
      end
    end else begin
      sel_sr_q    <= {sel_sr_q[LAT-3:0], active_pat_q};
      pat_sr_q[0] <= pat_d;
      for (int i = 1; i < LAT - 1; i++) begin
        pat_sr_q[i] <= pat_sr_q[i-1];
      end
    end
  end

  // Colour mux: blank outside the display area, else pattern or RAM data.
  always_comb begin
    rgb_d = '0;
    if (pe_sr_q[LAT-2]) begin
      rgb_d = sel_sr_q[LAT-2] ? pat_sr_q[LAT-2] : mem_if.mem_rdata;
    end
  end

  // Output colour register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign mem_if.mem_re   = mem_re_q;
  assign mem_if.mem_addr = mem_addr_q;
  assign vga_hs_o        = hs_sr_q[LAT-1];
  assign vga_vs_o        = vs_sr_q[LAT-1];
  assign pixel_valid_o   = pe_sr_q[LAT-1];
  assign rgb_o           = rgb_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader with a tiny VGA timing (H active/1/1/1, V active/1/1/1)
// and a 2-cycle RAM model that returns addr[11:0].
module tb_vga_fb_reader;

  localparam int NMAX = 2048;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        vga_hs_i, vga_vs_i, pixel_enable_i;
  logic [10:0] hcount_i;
  logic [9:0]  vcount_i;
  logic [18:0] base_addr_i, stride_i;
  logic        pattern_en_i, we_i;
  logic        vga_hs_o, vga_vs_o, pixel_valid_o;
  logic [11:0] rgb_o;

  always #5 clk_i = ~clk_i;

  vga_fb_reader_if #(.ADDR_WIDTH(19), .PIX_WIDTH(12)) mem ();

  vga_fb_reader dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .vga_hs_i       (vga_hs_i),
    .vga_vs_i       (vga_vs_i),
    .pixel_enable_i (pixel_enable_i),
    .hcount_i       (hcount_i),
    .vcount_i       (vcount_i),
    .base_addr_i    (base_addr_i),
    .stride_i       (stride_i),
    .pattern_en_i   (pattern_en_i),
    .we_i           (we_i),
    .mem_if         (mem),
    .vga_hs_o       (vga_hs_o),
    .vga_vs_o       (vga_vs_o),
    .pixel_valid_o  (pixel_valid_o),
    .rgb_o          (rgb_o)
  );

  // RAM with two cycles of read latency, data = low 12 address bits.
  logic [11:0] ram_d1, ram_d2;
  always @(posedge clk_i) begin
    ram_d1 <= mem.mem_addr[11:0];
    ram_d2 <= ram_d1;
  end
  assign mem.mem_rdata = ram_d2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Per-tick record: inputs applied before the edge, outputs sampled 1 ns after it.
  logic        in_hs [NMAX];
  logic        in_vs [NMAX];
  logic        in_pe [NMAX];
  int          in_h  [NMAX];
  int          in_v  [NMAX];
  logic        o_hs  [NMAX];
  logic        o_vs  [NMAX];
  logic        o_val [NMAX];
  logic        o_re  [NMAX];
  logic [18:0] o_addr[NMAX];
  logic [11:0] o_rgb [NMAX];

  logic [18:0] got_q[$];
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs, input logic pe, input int h, input int v);
    if (cyc >= NMAX) begin
      $display("FAIL tick_budget: observed %0d expected < %0d", cyc, NMAX);
      $fatal(1, "tick budget exhausted");
    end
    vga_hs_i       = hs;
    vga_vs_i       = vs;
    pixel_enable_i = pe;
    hcount_i       = 11'(h);
    vcount_i       = 10'(v);
    in_hs[cyc] = hs; in_vs[cyc] = vs; in_pe[cyc] = pe; in_h[cyc] = h; in_v[cyc] = v;
    @(posedge clk_i);
    #1;
    o_hs[cyc]   = vga_hs_o;
    o_vs[cyc]   = vga_vs_o;
    o_val[cyc]  = pixel_valid_o;
    o_re[cyc]   = mem.mem_re;
    o_addr[cyc] = mem.mem_addr;
    o_rgb[cyc]  = rgb_o;
    cyc++;
    we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic we_tick(input logic [18:0] base, input logic [18:0] stride, input logic pat);
    base_addr_i  = base;
    stride_i     = stride;
    pattern_en_i = pat;
    we_i         = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  // Lines v0..v1; hsync low at h == hact+1, vsync low on line vact+1.
  task automatic run_lines(input int v0, input int v1, input int hact, input int vact);
    for (int v = v0; v <= v1; v++)
      for (int h = 0; h < hact + 3; h++)
        tick(h != hact + 1, v != vact + 1, (h < hact) && (v < vact), h, v);
  endtask

  task automatic vsync_block(input int hact, input int vact);
    run_lines(vact, vact + 2, hact, vact);
  endtask

  task automatic check_addrs(input string tag, input int a, input int b);
    got_q.delete();
    for (int c = a; c < b; c++) if (o_re[c]) got_q.push_back(o_addr[c]);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic check_rgbs(input string tag, input int a, input int b);
    got_q.delete();
    for (int c = a; c < b; c++) if (o_val[c]) got_q.push_back(19'(o_rgb[c]));
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got_q[i], 32'(exp_q[i][11:0]));
  endtask

  function automatic int find_tick(input int a, input int b, input int h, input int v);
    for (int c = a; c < b; c++)
      if (in_pe[c] && in_h[c] == h && in_v[c] == v) return c;
    return -1;
  endfunction

  initial begin
    int va, a, b, c0, re_seen;

    arstn_i = 1'b0; we_i = 1'b0;
    vga_hs_i = 1'b1; vga_vs_i = 1'b1; pixel_enable_i = 1'b0;
    hcount_i = '0; vcount_i = '0;
    base_addr_i = '0; stride_i = '0; pattern_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_hs", vga_hs_o, 1);
    chk("rst_vs", vga_vs_o, 1);
    chk("rst_valid", pixel_valid_o, 0);
    chk("rst_rgb", rgb_o, 0);
    chk("rst_re", mem.mem_re, 0);
    chk("rst_addr", mem.mem_addr, 0);
    arstn_i = 1'b1;

    // Frame A: base 0x100, stride 4, 4x3 active.
    we_tick(19'h100, 19'h4, 1'b0);
    va = cyc;
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 2, 4, 3);
    b = cyc;
    idle(4);
    exp_q = '{19'h100, 19'h101, 19'h102, 19'h103, 19'h104, 19'h105,
              19'h106, 19'h107, 19'h108, 19'h109, 19'h10A, 19'h10B};
    check_addrs("lineaddr", a, b);
    check_rgbs("fb_rgb", a, cyc);
    // Pixel applied at tick a reaches the pins three ticks later (four clock cycles).
    chk("lat_valid_early", o_val[a+2], 0);
    chk("lat_valid", o_val[a+3], 1);
    chk("lat_rgb", o_rgb[a+3], 12'h100);
    for (int c = va; c < b; c++) begin
      chk("dly_hs", o_hs[c+3], in_hs[c]);
      chk("dly_vs", o_vs[c+3], in_vs[c]);
      chk("dly_valid", o_val[c+3], in_pe[c]);
    end

    // Frame B: base rewritten to 0x200 between lines 0 and 1; current frame unaffected.
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 0, 4, 3);
    we_tick(19'h200, 19'h4, 1'b0);
    run_lines(1, 2, 4, 3);
    b = cyc;
    check_addrs("midframe", a, b);
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 0, 4, 3);
    exp_q = '{19'h200, 19'h201, 19'h202, 19'h203};
    check_addrs("nextframe", a, cyc);

    // Address wrap at the top of the address space.
    we_tick(19'h7FFFE, 19'h4, 1'b0);
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 1, 4, 3);
    exp_q = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001,
              19'h00002, 19'h00003, 19'h00004, 19'h00005};
    check_addrs("wrap", a, cyc);

    // Stride 0 re-reads the same line.
    we_tick(19'h040, 19'h0, 1'b0);
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 2, 4, 3);
    exp_q = '{19'h40, 19'h41, 19'h42, 19'h43, 19'h40, 19'h41,
              19'h42, 19'h43, 19'h40, 19'h41, 19'h42, 19'h43};
    check_addrs("stride0", a, cyc);

    // Test pattern, 8x4 active so (5,3) lies inside the display area.
    we_tick(19'h100, 19'h4, 1'b1);
    vsync_block(8, 4);
    a = cyc;
    run_lines(0, 3, 8, 4);
    b = cyc;
    idle(4);
    re_seen = 0;
    for (int c = a; c < cyc; c++) if (o_re[c]) re_seen++;
    chk("pat_no_re", re_seen, 0);
    chk("pat_addr_hold", o_addr[cyc-1], 19'h43);
    c0 = find_tick(a, b, 5, 3);
    chk("pat_find_53", c0 >= 0, 1);
    if (c0 >= 0) chk("pat_53", o_rgb[c0+3], 12'h536);
    c0 = find_tick(a, b, 7, 2);
    if (c0 >= 0) chk("pat_72", o_rgb[c0+3], 12'h725);
    c0 = find_tick(a, b, 3, 1);
    if (c0 >= 0) chk("pat_31", o_rgb[c0+3], 12'h312);
    c0 = find_tick(a, b, 0, 0);
    if (c0 >= 0) chk("pat_00_valid", o_val[c0+3], 1);

    // Asynchronous reset in the middle of a framebuffer line.
    we_tick(19'h100, 19'h4, 1'b0);
    vsync_block(4, 3);
    for (int h = 0; h < 4; h++) tick(1'b1, 1'b1, 1'b1, h, 0);
    chk("pre_rst_valid", pixel_valid_o, 1);
    chk("pre_rst_rgb", rgb_o, 12'h100);
    chk("pre_rst_re", mem.mem_re, 1);
    chk("pre_rst_addr", mem.mem_addr, 19'h103);
    #2;
    arstn_i = 1'b0;
    #1;
    chk("arst_rgb", rgb_o, 0);
    chk("arst_hs", vga_hs_o, 1);
    chk("arst_vs", vga_vs_o, 1);
    chk("arst_valid", pixel_valid_o, 0);
    chk("arst_re", mem.mem_re, 0);
    chk("arst_addr", mem.mem_addr, 0);
    vga_hs_i = 1'b1; vga_vs_i = 1'b1; pixel_enable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    arstn_i = 1'b1;

    // First frame after reset takes whatever the shadow holds at vsync.
    we_tick(19'h300, 19'h2, 1'b0);
    vsync_block(4, 3);
    a = cyc;
    run_lines(0, 1, 4, 3);
    b = cyc;
    idle(4);
    exp_q = '{19'h300, 19'h301, 19'h302, 19'h303, 19'h302, 19'h303, 19'h304, 19'h305};
    check_addrs("post_rst", a, b);
    check_rgbs("post_rst_rgb", a, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
